// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES-128/192/256 encrypt/decrypt control FSM driving the state matrix, key load and round-key store.
module aes_round_sequencer #(
  parameter int LANES = 1,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             decrypt,
  input  logic             key_expand_done,
  input  logic             read_req,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             key_start,
  output logic             key_wr_en,
  output logic [2:0]       key_word_idx,
  output logic [3:0]       op_sel,
  output logic             wr_en,
  output logic             in_row_col,
  output logic [IDX_W-1:0] in_idx,
  output logic             out_row_col,
  output logic [IDX_W-1:0] out_idx,
  output logic [3:0]       rk_idx,
  output logic [4:0]       dbg_state,
  output logic [3:0]       dbg_round
);
  localparam int BEATS = 4 / LANES;
  localparam logic [3:0] OP_LOAD = 4'd0, OP_SUB = 4'd1, OP_SHIFT = 4'd2, OP_MIX = 4'd3,
                         OP_ARK = 4'd4, OP_ISUB = 4'd5, OP_ISHIFT = 4'd6, OP_IMIX = 4'd7;
  typedef enum logic [4:0] {
    IDLE = 5'd0, LOAD_PT = 5'd1, LOAD_KEY = 5'd2, KEY_EXP = 5'd3, INIT_ARK = 5'd4,
    P1 = 5'd5, P2 = 5'd6, P3 = 5'd7, P4 = 5'd8, DONE = 5'd9, READ = 5'd10
  } state_t;
  state_t state_q, state_d, nxt;
  logic [2:0] beat_q, beat_d;
  logic [3:0] round_q, round_d;
  logic [1:0] kl_q, kl_d;
  logic dec_q, dec_d, err_q;
  logic [3:0] nr;
  logic [2:0] nk_last;
  logic [IDX_W-1:0] idx;
  logic last, last_rnd, cnt, fin, proc, eor, rc;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      round_q <= '0;
      kl_q    <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      round_q <= round_d;
      kl_q    <= kl_d;
      dec_q   <= dec_d;
      err_q   <= state_q == IDLE && start && key_len == 2'd3;
    end
  assign nr       = 4'd10 + {1'b0, kl_q, 1'b0};
  assign nk_last  = 3'd3 + {kl_q, 1'b0};
  assign idx      = IDX_W'(beat_q * LANES);
  assign last     = beat_q == 3'(BEATS - 1);
  assign last_rnd = round_q == nr;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = err_q;
  assign dbg_state = state_q;
  assign dbg_round = round_q;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    round_d = round_q;
    kl_d = kl_q;
    dec_d = dec_q;
    nxt = state_q;
    cnt = 1'b0;
    fin = last;
    proc = 1'b0;
    eor = 1'b0;
    key_start = 1'b0;
    key_wr_en = 1'b0;
    key_word_idx = '0;
    op_sel = OP_LOAD;
    wr_en = 1'b0;
    in_row_col = 1'b0;
    in_idx = '0;
    out_row_col = 1'b0;
    out_idx = '0;
    rk_idx = '0;
    case (state_q)
      IDLE: if (start && key_len != 2'd3) begin
        state_d = LOAD_PT;
        kl_d = key_len;
        dec_d = decrypt;
        round_d = '0;
        beat_d = '0;
      end
      LOAD_PT: begin
        cnt = 1'b1;
        nxt = LOAD_KEY;
        wr_en = 1'b1;
        in_row_col = 1'b1;
        in_idx = idx;
        key_start = last;
      end
      LOAD_KEY: begin
        cnt = 1'b1;
        fin = beat_q == nk_last;
        nxt = KEY_EXP;
        key_wr_en = 1'b1;
        key_word_idx = beat_q;
      end
      KEY_EXP: if (key_expand_done) begin
        state_d = INIT_ARK;
        round_d = 4'd1;
      end
      INIT_ARK: begin
        proc = 1'b1;
        nxt = P1;
        op_sel = OP_ARK;
        rk_idx = dec_q ? nr : 4'd0;
      end
      P1: begin
        proc = 1'b1;
        nxt = P2;
        op_sel = dec_q ? OP_ISHIFT : OP_SUB;
      end
      P2: begin
        proc = 1'b1;
        nxt = (!dec_q && last_rnd) ? P4 : P3;
        op_sel = dec_q ? OP_ISUB : OP_SHIFT;
      end
      P3: begin
        proc = 1'b1;
        eor = dec_q && last_rnd;
        nxt = eor ? DONE : P4;
        op_sel = dec_q ? OP_ARK : OP_MIX;
        rk_idx = dec_q ? nr - round_q : 4'd0;
      end
      P4: begin
        proc = 1'b1;
        eor = 1'b1;
        nxt = last_rnd ? DONE : P1;
        op_sel = dec_q ? OP_IMIX : OP_ARK;
        rk_idx = dec_q ? 4'd0 : round_q;
      end
      DONE: if (read_req) state_d = READ;
      READ: begin
        cnt = 1'b1;
        nxt = IDLE;
        out_row_col = 1'b1;
        out_idx = idx;
      end
      default: state_d = IDLE;
    endcase
    rc = !(op_sel == OP_SHIFT || op_sel == OP_ISHIFT);
    if (proc) begin
      cnt = 1'b1;
      wr_en = 1'b1;
      in_row_col = rc;
      out_row_col = rc;
      in_idx = idx;
      out_idx = idx;
    end
    if (cnt) begin
      beat_d = fin ? 3'd0 : beat_q + 3'd1;
      if (fin) state_d = nxt;
      if (fin && eor && !last_rnd) round_d = round_q + 4'd1;
      if (fin && nxt == IDLE) round_d = '0;
    end
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      beat_d = '0;
      round_d = '0;
    end
  end
endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Parametrised second-generation AES control FSM. It sequences state-matrix load, key load, key-expansion wait, the initial AddRoundKey, Nr rounds and ciphertext readout. Beyond the first generation it adds: runtime AES-128/192/256 (Nr = 10/12/14), encrypt or decrypt ordering, LANES columns/rows per beat, a round-key index output, a start/busy handshake, and abort. It sits between the host interface and the state-matrix datapath, key expansion unit and round-key store.

Parameters:
LANES, 1, columns (or rows) processed per beat; legal values 1, 2, 4; BEATS = 4/LANES.
IDX_W, 2, width of the matrix index outputs.

Ports:
clock  in  1  clock
reset_n  in  1  async active-low reset
start  in  1  request a new operation; accepted only in IDLE
key_len  in  2  0=128, 1=192, 2=256, 3=illegal; sampled when start is accepted
decrypt  in  1  0=encrypt, 1=decrypt; sampled when start is accepted
key_expand_done  in  1  level, round keys ready
read_req  in  1  host requests ciphertext readout
abort  in  1  synchronous abort
busy  out  1  high in every state except IDLE
done  out  1  high while in DONE
err  out  1  one-cycle pulse when start is rejected
key_start  out  1  one-cycle pulse on the last LOAD_PT beat
key_wr_en  out  1  high during LOAD_KEY
key_word_idx  out  3  key word being loaded (0..Nk-1)
op_sel  out  4  0 load, 1 sub, 2 shift, 3 mix, 4 ark, 5 invsub, 6 invshift, 7 invmix
wr_en  out  1  matrix write enable
in_row_col  out  1  write orientation: 0 row, 1 column
in_idx  out  IDX_W  base write index = beat*LANES
out_row_col  out  1  read orientation
out_idx  out  IDX_W  base read index = beat*LANES
rk_idx  out  4  round-key index for ark
dbg_state  out  5  current state code
dbg_round  out  4  round counter

Behaviour:
- Reset: state IDLE; round counter, beat counter and every output at 0.
- State codes: IDLE=0, LOAD_PT=1, LOAD_KEY=2, KEY_EXP=3, INIT_ARK=4, P1=5, P2=6, P3=7, P4=8, DONE=9, READ=10.
- IDLE: on start with key_len≠3, latch key_len and decrypt, round=0, beat=0, go to LOAD_PT. On start with key_len=3, stay in IDLE and pulse err the next cycle.
- start outside IDLE is ignored.
- LOAD_PT: BEATS beats; op_sel=0, wr_en=1, in_row_col=1. key_start is high on the last beat.
- LOAD_KEY: Nk = 4/6/8 beats, one key word per beat regardless of LANES; key_wr_en=1, key_word_idx = beat.
- KEY_EXP: hold until key_expand_done is seen; minimum 1 cycle. Then round=1 and go to INIT_ARK.
- INIT_ARK: BEATS beats; op_sel=4. rk_idx=0 for encrypt, Nr for decrypt.
- Round phases run P1 to P4, BEATS beats each.
  - Encrypt: P1=sub, P2=shift, P3=mix, P4=ark.
  - Decrypt: P1=invshift, P2=invsub, P3=ark, P4=invmix.
- Row/column orientation: shift and invshift use row orientation (row_col=0); all other ops use column orientation (1).
- Processing phases: wr_en=1; in_* equal out_*.
- rk_idx during ark: round for encrypt, Nr−round for decrypt; 0 outside ark.
- Last round (round==Nr): encrypt skips mix (P2 goes to P4); decrypt skips invmix (P3 ends the round).
- End of round: if round<Nr, round++ and go to P1; else go to DONE.
- DONE: done=1; on read_req go to READ.
- READ: BEATS beats; wr_en=0, out_row_col=1; then return to IDLE.
- abort, in any non-IDLE state: next cycle IDLE with all counters cleared. abort beats read_req and key_expand_done in the same cycle.
- Beat counter wraps to 0 at every phase exit.
- dbg_round = round counter.
- Latency from start accepted to first DONE cycle, with key_expand_done high: LANES=1, AES-128 encrypt = 169 cycles; LANES=4 = 46 cycles.
- Mid-operation reset: outputs return to reset values asynchronously.

Test Plan:
- LANES=1, key_len=0, decrypt=0, key_expand_done high -> done first high 169 cycles after start; rk_idx during ark phases is 0,1,…,10; op_sel never 3 in round 10.
- LANES=4, key_len=2, decrypt=1 -> 14 rounds; rk_idx 14 in INIT_ARK then 13…0; no invmix after the ark with rk_idx=0.
- key_len=3 with start -> stays in IDLE, err is a 1-cycle pulse, busy stays 0.
- abort asserted in P3 of round 5 -> IDLE next cycle; busy=0, dbg_round=0; a new start then runs to completion.
- key_expand_done held low for 20 cycles -> sequencer stays in KEY_EXP for 20 cycles; key_word_idx 0..5 seen earlier in LOAD_KEY for key_len=1.
- LANES=2, READ phase -> out_idx 0 then 2; return to IDLE; start issued during DONE is ignored.
